tmds_channel_encoder: RTL and testbench



---
 rtl/video_pkg.sv | 18 +
 rtl/tmds_channel_encoder.sv | 91 +++++++++
 tb/tb_tmds_channel_encoder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// video_pkg: shared TMDS control tokens, symbol type and popcount helper
package video_pkg;

  typedef logic [9:0] tmds_symbol_t;

  localparam tmds_symbol_t TMDS_CTRL_00 = 10'b1101010100;
  localparam tmds_symbol_t TMDS_CTRL_01 = 10'b0010101011;
  localparam tmds_symbol_t TMDS_CTRL_10 = 10'b0101010100;
  localparam tmds_symbol_t TMDS_CTRL_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// tmds_channel_encoder: per-channel DVI/TMDS 8b/10b encoder with running disparity
module tmds_channel_encoder
  import video_pkg::*;
#(
  parameter bit REGISTER_INPUT = 1'b1
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic [7:0]   data_i,
  input  logic [1:0]   ctrl_i,
  input  logic         de_i,
  output tmds_symbol_t tmds_o
);

  logic [7:0]        d;
  logic [1:0]        c;
  logic              e;
  logic [3:0]        n1d;
  logic              use_xnor;
  logic [8:0]        q_m;
  logic [3:0]        n1;
  logic signed [4:0] diff;
  logic signed [4:0] cnt;
  logic signed [4:0] cnt_n;
  tmds_symbol_t      sym_n;

  function automatic logic [7:0] chain(input logic [7:0] v, input logic x);
    logic [7:0] t;
    t[0] = v[0];
    for (int i = 1; i < 8; i++) t[i] = x ? ~(t[i-1] ^ v[i]) : (t[i-1] ^ v[i]);
    return t;
  endfunction

  if (REGISTER_INPUT) begin : g_in_reg
    // capture the pixel, control pair and enable together so they stay aligned
    always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) begin
        d <= '0;
        c <= '0;
        e <= 1'b0;
      end else begin
        d <= data_i;
        c <= ctrl_i;
        e <= de_i;
      end
  end else begin : g_in_comb
    assign d = data_i;
    assign c = ctrl_i;
    assign e = de_i;
  end

  // transition minimisation: pick XOR or XNOR chain by ones count
  always_comb begin
    n1d      = popcount8(d);
    use_xnor = (n1d > 4'd4) || (n1d == 4'd4 && !d[0]);
    q_m      = {~use_xnor, chain(d, use_xnor)};
  end

  // DC balance: choose inversion from running disparity, control tokens reset it
  always_comb begin
    n1    = popcount8(q_m[7:0]);
    diff  = {n1, 1'b0} - 5'd8;
    sym_n = {1'b0, q_m};
    cnt_n = cnt;
    if (!e) begin
      sym_n = c == 2'b00 ? TMDS_CTRL_00 : c == 2'b01 ? TMDS_CTRL_01 :
              c == 2'b10 ? TMDS_CTRL_10 : TMDS_CTRL_11;
      cnt_n = 5'sd0;
    end else if (cnt == 5'sd0 || diff == 5'sd0) begin
      sym_n = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      cnt_n = cnt + (q_m[8] ? diff : -diff);
    end else if ((cnt > 5'sd0 && diff > 5'sd0) || (cnt < 5'sd0 && diff < 5'sd0)) begin
      sym_n = {1'b1, q_m[8], ~q_m[7:0]};
      cnt_n = cnt + $signed({3'b000, q_m[8], 1'b0}) - diff;
    end else begin
      sym_n = {1'b0, q_m[8], q_m[7:0]};
      cnt_n = cnt + diff - $signed({3'b000, ~q_m[8], 1'b0});
    end
  end

  // output symbol and running disparity register
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      tmds_o <= TMDS_CTRL_00;
      cnt    <= 5'sd0;
    end else begin
      tmds_o <= sym_n;
      cnt    <= cnt_n;
    end

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// tb_tmds_channel_encoder: directed and model-checked bench for the TMDS encoder
module tb_tmds_channel_encoder;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic [7:0] data_i = '0;
  logic [1:0] ctrl_i = '0;
  logic       de_i = 1'b0;
  logic [9:0] tmds_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] pd = '0;
  logic [1:0] pc = '0;
  logic       pe = 1'b0;
  int         mcnt = 0;
  logic [9:0] exp_t = 10'h354;

  tmds_channel_encoder #(.REGISTER_INPUT(1'b1)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .data_i(data_i),
    .ctrl_i(ctrl_i), .de_i(de_i), .tmds_o(tmds_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [9:0] token(input logic [1:0] cv);
    case (cv)
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  task automatic model_encode();
    int n1d, n1, n0;
    logic x;
    logic [8:0] q;
    if (!pe) begin
      exp_t = token(pc);
      mcnt  = 0;
    end else begin
      n1d  = $countones(pd);
      x    = (n1d > 4) || (n1d == 4 && pd[0] == 1'b0);
      q[0] = pd[0];
      for (int i = 1; i < 8; i++) q[i] = x ? ~(q[i-1] ^ pd[i]) : (q[i-1] ^ pd[i]);
      q[8] = ~x;
      n1 = $countones(q[7:0]);
      n0 = 8 - n1;
      if (mcnt == 0 || n1 == n0) begin
        exp_t = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
        mcnt += q[8] ? (n1 - n0) : (n0 - n1);
      end else if ((mcnt > 0 && n1 > n0) || (mcnt < 0 && n0 > n1)) begin
        exp_t = {1'b1, q[8], ~q[7:0]};
        mcnt += (q[8] ? 2 : 0) + n0 - n1;
      end else begin
        exp_t = {1'b0, q[8], q[7:0]};
        mcnt += n1 - n0 - (q[8] ? 0 : 2);
      end
    end
  endtask

  task automatic model_reset();
    pd = '0; pc = '0; pe = 1'b0; mcnt = 0; exp_t = 10'h354;
  endtask

  task automatic step(input logic [7:0] d, input logic [1:0] cv, input logic e);
    data_i = d;
    ctrl_i = cv;
    de_i   = e;
    @(posedge clk_i);
    model_encode();
    pd = d; pc = cv; pe = e;
    #1;
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(posedge clk_i);
      #1;
      checks++;
      if (tmds_o !== 10'h354) begin
        errors++;
        $display("FAIL reset_hold: tmds_o=%h expected=354", tmds_o);
      end
    end
    rstn_i = 1'b1;
    model_reset();
    step(8'h00, 2'b00, 1'b0);
    checks++;
    if (tmds_o !== 10'h354 || dut.cnt !== 5'sd0) begin
      errors++;
      $display("FAIL reset_release: tmds_o=%h cnt=%0d expected=354 cnt=0", tmds_o, dut.cnt);
    end
  endtask

  task automatic test_ctrl();
    logic [1:0] seq [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10};
    logic [9:0] want [6] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB, 10'h354, 10'h154};
    for (int i = 0; i < 6; i++) step(8'h5A, seq[i], 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(8'h00, 2'b00, 1'b0);
      if (i == 0) begin
        checks++;
        if (tmds_o !== want[5]) begin
          errors++;
          $display("FAIL ctrl_latency: tmds_o=%h expected=%h", tmds_o, want[5]);
        end
      end
    end
    for (int i = 0; i < 6; i++) begin
      step(8'h00, seq[i], 1'b0);
      step(8'h00, seq[i], 1'b0);
      checks++;
      if (tmds_o !== want[i]) begin
        errors++;
        $display("FAIL ctrl_token_%0d: tmds_o=%h expected=%h", i, tmds_o, want[i]);
      end
    end
  endtask

  task automatic test_data_zero();
    step(8'h00, 2'b00, 1'b0);
    step(8'h00, 2'b00, 1'b1);
    step(8'h00, 2'b00, 1'b1);
    checks++;
    if (tmds_o !== 10'h100 || dut.cnt !== -5'sd8) begin
      errors++;
      $display("FAIL zero_first: tmds_o=%h cnt=%0d expected=100 cnt=-8", tmds_o, dut.cnt);
    end
    step(8'h00, 2'b01, 1'b0);
    checks++;
    if (tmds_o !== 10'h3FF || dut.cnt !== 5'sd2) begin
      errors++;
      $display("FAIL zero_second: tmds_o=%h cnt=%0d expected=3ff cnt=2", tmds_o, dut.cnt);
    end
    step(8'h00, 2'b00, 1'b0);
    checks++;
    if (tmds_o !== 10'h0AB || dut.cnt !== 5'sd0) begin
      errors++;
      $display("FAIL de_fall: tmds_o=%h cnt=%0d expected=0ab cnt=0", tmds_o, dut.cnt);
    end
  endtask

  task automatic test_data_ff();
    step(8'h00, 2'b00, 1'b0);
    step(8'hFF, 2'b00, 1'b1);
    step(8'h00, 2'b00, 1'b0);
    checks++;
    if (tmds_o !== 10'h200 || dut.cnt !== -5'sd8) begin
      errors++;
      $display("FAIL ff_first: tmds_o=%h cnt=%0d expected=200 cnt=-8", tmds_o, dut.cnt);
    end
    step(8'h00, 2'b00, 1'b0);
  endtask

  task automatic test_random();
    logic e = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 15) == 0) e = ~e;
      step(8'($urandom), 2'($urandom), e);
      checks++;
      if (tmds_o !== exp_t || int'(dut.cnt) != mcnt) begin
        errors++;
        $display("FAIL random_%0d: tmds_o=%h cnt=%0d expected=%h cnt=%0d", i, tmds_o, dut.cnt, exp_t, mcnt);
      end
      checks++;
      if (dut.cnt > 5'sd10 || dut.cnt < -5'sd10) begin
        errors++;
        $display("FAIL cnt_bound_%0d: cnt=%0d expected |cnt|<=10", i, dut.cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(8'h00, 2'b00, 1'b0);
    step(8'h00, 2'b00, 1'b1);
    step(8'h00, 2'b00, 1'b1);
    step(8'h00, 2'b00, 1'b1);
    checks++;
    if (dut.cnt !== 5'sd2) begin
      errors++;
      $display("FAIL mid_precond: cnt=%0d expected=2", dut.cnt);
    end
    #3;
    rstn_i = 1'b0;
    #1;
    checks++;
    if (tmds_o !== 10'h354 || dut.cnt !== 5'sd0) begin
      errors++;
      $display("FAIL async_reset: tmds_o=%h cnt=%0d expected=354 cnt=0", tmds_o, dut.cnt);
    end
    #1;
    rstn_i = 1'b1;
    model_reset();
    step(8'h00, 2'b00, 1'b1);
    checks++;
    if (tmds_o !== 10'h354) begin
      errors++;
      $display("FAIL post_reset_idle: tmds_o=%h expected=354", tmds_o);
    end
    step(8'h00, 2'b00, 1'b0);
    checks++;
    if (tmds_o !== 10'h100 || dut.cnt !== -5'sd8) begin
      errors++;
      $display("FAIL post_reset_case_a: tmds_o=%h cnt=%0d expected=100 cnt=-8", tmds_o, dut.cnt);
    end
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_data_zero();
    test_data_ff();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
